pwm_gate_monitor: RTL and testbench
===================================

PWM_GATE_MONITOR -- requirements
Module: pwm_gate_monitor

Interface
REQ-001 SHALL have parameter CNT_W, 8, width of all measurement counters and outputs.
REQ-002 SHALL have port clk_pwm  input  1  PWM-domain clock; all logic on its rising edge.
REQ-003 SHALL have port reset  input  1  reset, synchronous, active-high.
REQ-004 SHALL have port gate_hi  input  1  high-side gate drive, active-high, asynchronous to clk_pwm.
REQ-005 SHALL have port gate_lo  input  1  complementary low-side gate drive, active-high, asynchronous to clk_pwm.
REQ-006 SHALL have port dt_min  input  4  minimum allowed dead time, in clk_pwm cycles.
REQ-007 SHALL have port clr_flags  input  1  one-cycle pulse that clears sticky flags.
REQ-008 SHALL have port period  output  CNT_W  clk_pwm cycles between consecutive gate_hi rising edges.
REQ-009 SHALL have port on_time  output  CNT_W  gate_hi-high cycles within that period.
REQ-010 SHALL have port dt_rise  output  CNT_W  both-low cycles immediately before the gate_hi rise.
REQ-011 SHALL have port dt_fall  output  CNT_W  both-low cycles from gate_hi fall to the next gate_lo rise.
REQ-012 SHALL have port meas_valid  output  1  one-cycle pulse; measurement outputs updated.
REQ-013 SHALL have port fault_st  output  1  sticky shoot-through flag (gate_hi and gate_lo high together).
REQ-014 SHALL have port fault_dt  output  1  sticky flag; a published dt_rise or dt_fall was below dt_min.
REQ-015 SHALL have port timeout  output  1  sticky flag; no gate_hi rise within 2^CNT_W-1 cycles.

Function
REQ-016 SHALL pass gate_hi and gate_lo through 2-flop synchronizers (hi_s, lo_s); all rules below use hi_s/lo_s.
REQ-017 SHALL define rise as hi_s=1 with hi_s one cycle earlier =0.
REQ-018 SHALL implement FSM IDLE/MEAS; IDLE->MEAS on rise; MEAS->IDLE on timeout; MEAS self-loops otherwise.
REQ-019 SHALL publish nothing on the IDLE->MEAS rise, because that period is incomplete.
REQ-020 SHALL load the period counter with 1 on rise, then increment it every cycle.
REQ-021 SHALL, on a rise in MEAS, latch the period counter value into period.
REQ-022 SHALL count on_time cycles with hi_s=1, starting at the rise cycle, restarting at 1 on each rise.
REQ-023 SHALL count both-low run length (hi_s=0 and lo_s=0) and clear the count when either input is high.
REQ-024 SHALL take dt_rise from the run length at the rise.
REQ-025 SHALL take dt_fall from the run length at the first lo_s rise after the hi_s fall; if no lo_s rise occurs before the next rise, dt_fall SHALL equal the run length at that rise.
REQ-026 SHALL register all four results and meas_valid on the clock edge after the rise cycle; outputs hold until the next publish.
REQ-027 SHALL produce meas_valid at the 3rd clk_pwm edge counting the edge that first samples gate_hi=1 (2 sync + 1 register).
REQ-028 SHALL saturate every counter at 2^CNT_W-1, with no wrap.
REQ-029 SHALL set timeout and return to IDLE when the period counter saturates in MEAS, with no publish.
REQ-030 SHALL set fault_st in any cycle where hi_s=1 and lo_s=1, independent of FSM state.
REQ-031 SHALL, at each publish, set fault_dt if dt_rise<dt_min or dt_fall<dt_min, using unsigned compare with dt_min zero-extended.
REQ-032 SHALL clear the sticky flags on clr_flags; if a set and clr_flags occur in the same cycle, the set SHALL win.
REQ-033 SHALL clear no measurement outputs on clr_flags.

Reset
REQ-034 SHALL drive, while reset=1: FSM=IDLE; period, on_time, dt_rise, dt_fall =0; meas_valid, fault_st, fault_dt, timeout =0; synchronizer and counter flops =0.
REQ-035 SHALL, on reset mid-period, discard the partial measurement; the first rise after reset is treated as IDLE->MEAS.

Verification
REQ-036 SHALL cover: hi high 38 / both low 2 / lo high 38 / both low 2, repeated -> from the 2nd rise on, period=80, on_time=38, dt_rise=2, dt_fall=2, meas_valid once per 80 cycles, no flags.
REQ-037 SHALL cover: same waveform with dt_min=3 -> fault_dt=1 after the first publish; clr_flags pulse -> fault_dt=0 and re-sets at the next publish.
REQ-038 SHALL cover: hi and lo both high for 1 cycle -> fault_st=1 and held; clr_flags in the same cycle as a second overlap -> fault_st stays 1.
REQ-039 SHALL cover: hi held low for 300 cycles after one rise, CNT_W=8 -> timeout=1 at period counter 255, FSM IDLE, no meas_valid; the next two rises publish only on the second.
REQ-040 SHALL cover: reset asserted for 1 cycle at cycle 40 of a period -> all outputs 0; the first post-reset rise gives no meas_valid, the second gives a correct period.
REQ-041 SHALL cover: gate_hi edge on a cycle boundary -> meas_valid exactly 3 edges after the first sampling, with values matching REQ-036.

Source files
------------

// File: rtl/pwm_gate_monitor.sv
// rtl/pwm_gate_monitor.sv - measures period, on-time and dead times of a complementary gate pair
// Flags shoot-through, dead-time violations and missing PWM activity.
module pwm_gate_monitor #(
    parameter int CNT_W = 8
) (
    input  logic             clk_pwm,
    input  logic             reset,
    input  logic             gate_hi,
    input  logic             gate_lo,
    input  logic [3:0]       dt_min,
    input  logic             clr_flags,
    output logic [CNT_W-1:0] period,
    output logic [CNT_W-1:0] on_time,
    output logic [CNT_W-1:0] dt_rise,
    output logic [CNT_W-1:0] dt_fall,
    output logic             meas_valid,
    output logic             fault_st,
    output logic             fault_dt,
    output logic             timeout
);

    localparam logic [CNT_W-1:0] CNT_MAX = '1;
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    typedef enum logic {IDLE, MEAS} state_t;

    state_t state_q, state_d;

    logic hi_m, hi_s, hi_d;
    logic lo_m, lo_s, lo_d;
    logic rise, hi_fall, lo_rise;
    logic publish, timeout_set;

    logic [CNT_W-1:0] per_cnt, on_cnt, run_cnt, fall_cap, fall_val, dt_min_ext;
    logic             fall_armed, fall_seen;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (v == CNT_MAX) ? v : v + CNT_ONE;
    endfunction

    always_ff @(posedge clk_pwm) begin
        if (reset) begin
            {hi_m, hi_s, hi_d} <= 3'b000;
            {lo_m, lo_s, lo_d} <= 3'b000;
        end else begin
            hi_m <= gate_hi;
            hi_s <= hi_m;
            hi_d <= hi_s;
            lo_m <= gate_lo;
            lo_s <= lo_m;
            lo_d <= lo_s;
        end
    end

    assign rise       = hi_s & ~hi_d;
    assign hi_fall    = ~hi_s & hi_d;
    assign lo_rise    = lo_s & ~lo_d;
    assign fall_val   = fall_seen ? fall_cap : run_cnt;
    assign dt_min_ext = CNT_W'(dt_min);

    always_ff @(posedge clk_pwm) begin
        if (reset) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        publish     = 1'b0;
        timeout_set = 1'b0;
        case (state_q)
            IDLE: begin
                if (rise) begin
                    state_d = MEAS;
                end
            end
            MEAS: begin
                if (rise) begin
                    publish = 1'b1;
                end else if (per_cnt == CNT_MAX) begin
                    timeout_set = 1'b1;
                    state_d     = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_pwm) begin
        if (reset) begin
            per_cnt <= '0;
            on_cnt  <= '0;
            run_cnt <= '0;
        end else begin
            per_cnt <= rise ? CNT_ONE : sat_inc(per_cnt);
            if (rise) begin
                on_cnt <= CNT_ONE;
            end else if (hi_s) begin
                on_cnt <= sat_inc(on_cnt);
            end
            run_cnt <= (hi_s | lo_s) ? '0 : sat_inc(run_cnt);
        end
    end

    // A low-side rise coinciding with the high-side fall still closes the falling dead time.
    always_ff @(posedge clk_pwm) begin
        if (reset || rise) begin
            fall_armed <= 1'b0;
            fall_seen  <= 1'b0;
            fall_cap   <= '0;
        end else if (lo_rise && (fall_armed || hi_fall)) begin
            fall_armed <= 1'b0;
            fall_seen  <= 1'b1;
            fall_cap   <= run_cnt;
        end else if (hi_fall) begin
            fall_armed <= 1'b1;
        end
    end

    always_ff @(posedge clk_pwm) begin
        if (reset) begin
            period     <= '0;
            on_time    <= '0;
            dt_rise    <= '0;
            dt_fall    <= '0;
            meas_valid <= 1'b0;
        end else begin
            meas_valid <= publish;
            if (publish) begin
                period  <= per_cnt;
                on_time <= on_cnt;
                dt_rise <= run_cnt;
                dt_fall <= fall_val;
            end
        end
    end

    // Sticky flags: a set in the same cycle as clr_flags takes priority.
    always_ff @(posedge clk_pwm) begin
        if (reset) begin
            fault_st <= 1'b0;
            fault_dt <= 1'b0;
            timeout  <= 1'b0;
        end else begin
            if (hi_s && lo_s) begin
                fault_st <= 1'b1;
            end else if (clr_flags) begin
                fault_st <= 1'b0;
            end
            if (publish && ((run_cnt < dt_min_ext) || (fall_val < dt_min_ext))) begin
                fault_dt <= 1'b1;
            end else if (clr_flags) begin
                fault_dt <= 1'b0;
            end
            if (timeout_set) begin
                timeout <= 1'b1;
            end else if (clr_flags) begin
                timeout <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_pwm_gate_monitor.sv
// tb/tb_pwm_gate_monitor.sv - directed bench for pwm_gate_monitor
module tb_pwm_gate_monitor;

    logic       clk_pwm   = 1'b0;
    logic       reset     = 1'b1;
    logic       gate_hi   = 1'b0;
    logic       gate_lo   = 1'b0;
    logic [3:0] dt_min    = 4'd2;
    logic       clr_flags = 1'b0;
    logic [7:0] period, on_time, dt_rise, dt_fall;
    logic       meas_valid, fault_st, fault_dt, timeout;

    int vectors     = 0;
    int miscompares = 0;
    int mv_count    = 0;
    int mv_step     = -1;
    int to_step     = -1;

    pwm_gate_monitor #(.CNT_W(8)) dut (
        .clk_pwm(clk_pwm), .reset(reset), .gate_hi(gate_hi), .gate_lo(gate_lo),
        .dt_min(dt_min), .clr_flags(clr_flags), .period(period), .on_time(on_time),
        .dt_rise(dt_rise), .dt_fall(dt_fall), .meas_valid(meas_valid),
        .fault_st(fault_st), .fault_dt(fault_dt), .timeout(timeout)
    );

    always #5 clk_pwm = ~clk_pwm;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic step(input logic h, input logic l, input int idx);
        gate_hi = h;
        gate_lo = l;
        @(posedge clk_pwm);
        #1;
        if (meas_valid) begin
            mv_count++;
            mv_step = idx;
        end
    endtask

    // 80-cycle pattern: hi 38, both low 2, lo 38, both low 2
    task automatic run_range(input int a, input int b);
        for (int i = a; i < b; i++) step(i < 38, (i >= 40) && (i < 78), i);
    endtask

    task automatic do_reset();
        reset = 1'b1;
        step(1'b0, 1'b0, -1);
        reset = 1'b0;
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_period"}, {24'd0, period}, 32'd0);
        check({tag, "_on_time"}, {24'd0, on_time}, 32'd0);
        check({tag, "_dt_rise"}, {24'd0, dt_rise}, 32'd0);
        check({tag, "_dt_fall"}, {24'd0, dt_fall}, 32'd0);
        check({tag, "_flags"}, {28'd0, meas_valid, fault_st, fault_dt, timeout}, 32'd0);
    endtask

    initial begin
        step(1'b0, 1'b0, -1);
        step(1'b0, 1'b0, -1);
        check_all_zero("reset");
        reset = 1'b0;
        for (int i = 0; i < 5; i++) step(1'b0, 1'b0, -1);

        // steady waveform: first rise only arms, later rises publish
        mv_count = 0;
        run_range(0, 80);
        check("first_rise_no_pub", mv_count, 0);
        for (int p = 0; p < 3; p++) run_range(0, 80);
        check("steady_mv_count", mv_count, 3);
        check("steady_mv_latency", mv_step, 2);
        check("steady_period", {24'd0, period}, 32'd80);
        check("steady_on_time", {24'd0, on_time}, 32'd38);
        check("steady_dt_rise", {24'd0, dt_rise}, 32'd2);
        check("steady_dt_fall", {24'd0, dt_fall}, 32'd2);
        check("steady_no_flags", {29'd0, fault_st, fault_dt, timeout}, 32'd0);

        // dead time below dt_min, clear, re-set at next publish
        dt_min = 4'd3;
        run_range(0, 80);
        check("dt_fault_set", {31'd0, fault_dt}, 32'd1);
        run_range(0, 10);
        clr_flags = 1'b1;
        step(1'b1, 1'b0, 10);
        clr_flags = 1'b0;
        run_range(11, 80);
        check("dt_fault_cleared", {31'd0, fault_dt}, 32'd0);
        check("dt_clr_keeps_period", {24'd0, period}, 32'd80);
        run_range(0, 80);
        check("dt_fault_reset", {31'd0, fault_dt}, 32'd1);
        dt_min = 4'd2;

        // shoot-through
        do_reset();
        for (int i = 0; i < 3; i++) step(1'b0, 1'b0, -1);
        step(1'b1, 1'b1, -1);
        step(1'b0, 1'b0, -1);
        check("st_not_yet", {31'd0, fault_st}, 32'd0);
        step(1'b0, 1'b0, -1);
        check("st_set", {31'd0, fault_st}, 32'd1);
        for (int i = 0; i < 5; i++) step(1'b0, 1'b0, -1);
        check("st_held", {31'd0, fault_st}, 32'd1);
        clr_flags = 1'b1;
        step(1'b0, 1'b0, -1);
        clr_flags = 1'b0;
        check("st_cleared", {31'd0, fault_st}, 32'd0);
        step(1'b1, 1'b1, -1);
        step(1'b0, 1'b0, -1);
        clr_flags = 1'b1;
        step(1'b0, 1'b0, -1);
        clr_flags = 1'b0;
        check("st_set_beats_clr", {31'd0, fault_st}, 32'd1);

        // timeout after a single rise
        do_reset();
        mv_count = 0;
        for (int k = 1; k <= 305; k++) begin
            step(k <= 5, 1'b0, k);
            if (timeout && to_step < 0) to_step = k;
        end
        check("timeout_step", to_step, 258);
        check("timeout_no_pub", mv_count, 0);
        run_range(0, 80);
        check("timeout_idle_rearm", mv_count, 0);
        run_range(0, 80);
        check("timeout_second_pub", mv_count, 1);
        check("timeout_period", {24'd0, period}, 32'd80);
        check("timeout_on_time", {24'd0, on_time}, 32'd38);
        check("timeout_sticky", {31'd0, timeout}, 32'd1);

        // reset in the middle of a period
        do_reset();
        run_range(0, 80);
        run_range(0, 80);
        check("prereset_period", {24'd0, period}, 32'd80);
        run_range(0, 40);
        reset = 1'b1;
        step(1'b0, 1'b1, 40);
        reset = 1'b0;
        check_all_zero("midreset");
        run_range(41, 80);
        mv_count = 0;
        run_range(0, 80);
        check("postreset_first_no_pub", mv_count, 0);
        run_range(0, 80);
        check("postreset_pub", mv_count, 1);
        check("postreset_period", {24'd0, period}, 32'd80);
        check("postreset_dt_rise", {24'd0, dt_rise}, 32'd2);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
